// File: rtl/neo_memcard_pkg.sv
// Shared types and constants for the neo_memcard controller.
package neo_memcard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [7:0] CARD_EMPTY_DATA = 8'hFF;

endpackage

// File: rtl/neo_memcard.sv
// Memory card controller: one byte transaction per strobe assertion
// against a req/ack backing store, with 68k stall and dirty tracking.
module neo_memcard
   import neo_memcard_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              CLK_24M,
   input  logic              nRESET,
   input  logic [23:0]       CDA,
   input  logic              nCRDC,
   input  logic              nCRDO,
   input  logic              nCRDW,
   input  logic [7:0]        M68K_DATA_LO,
   output logic [7:0]        CARD_DATA,
   output logic              nCARD_WAIT,
   input  logic              CARD_INSERTED,
   input  logic              CARD_WP,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [7:0]        MEM_WDATA,
   output logic              MEM_WE,
   output logic              MEM_REQ,
   input  logic              MEM_ACK,
   input  logic [7:0]        MEM_RDATA,
   output logic              DIRTY,
   input  logic              DIRTY_CLR
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_req_q, mem_req_d;
   logic [7:0]        card_data_q, card_data_d;
   logic              dirty_q, dirty_d;

   logic sel;
   logic wr;

   // Upper CDA bits only mirror the card; keep them visibly consumed.
   logic unused_cda;
   assign unused_cda = ^CDA;

   assign sel = ~nCRDC & (~nCRDO | ~nCRDW);
   assign wr  = ~nCRDW;

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      mem_req_d   = mem_req_q;
      card_data_d = card_data_q;
      dirty_d     = dirty_q & ~DIRTY_CLR;

      unique case (state_q)
         ST_IDLE: begin
            if (sel) begin
               mem_addr_d  = CDA[ADDR_W-1:0];
               mem_wdata_d = M68K_DATA_LO;
               mem_we_d    = wr;
               if (CARD_INSERTED && !(wr && CARD_WP)) begin
                  mem_req_d = 1'b1;
                  state_d   = ST_REQ;
               end else begin
                  if (!wr)
                     card_data_d = CARD_EMPTY_DATA;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_REQ: begin
            if (MEM_ACK) begin
               mem_req_d = 1'b0;
               // A completing write outranks a same-cycle host clear.
               if (mem_we_q)
                  dirty_d = 1'b1;
               else
                  card_data_d = MEM_RDATA;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!sel)
               state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         state_q     <= ST_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         card_data_q <= CARD_EMPTY_DATA;
         dirty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_req_q   <= mem_req_d;
         card_data_q <= card_data_d;
         dirty_q     <= dirty_d;
      end
   end

   assign nCARD_WAIT = ~(((state_q == ST_IDLE) & sel) | (state_q == ST_REQ));
   assign MEM_ADDR   = mem_addr_q;
   assign MEM_WDATA  = mem_wdata_q;
   assign MEM_WE     = mem_we_q;
   assign MEM_REQ    = mem_req_q;
   assign CARD_DATA  = card_data_q;
   assign DIRTY      = dirty_q;

endmodule

// File: tb/tb_neo_memcard.sv
// Directed self-checking bench for neo_memcard.
module tb_neo_memcard;

   logic        clk;
   logic        nRESET;
   logic [23:0] CDA;
   logic        nCRDC, nCRDO, nCRDW;
   logic [7:0]  M68K_DATA_LO;
   logic [7:0]  CARD_DATA;
   logic        nCARD_WAIT;
   logic        CARD_INSERTED, CARD_WP;
   logic [10:0] MEM_ADDR;
   logic [7:0]  MEM_WDATA;
   logic        MEM_WE, MEM_REQ, MEM_ACK;
   logic [7:0]  MEM_RDATA;
   logic        DIRTY, DIRTY_CLR;

   int checks = 0;
   int errors = 0;

   int          wl, rq;
   logic [10:0] sa;
   logic        swe;
   logic [7:0]  swd;

   neo_memcard #(.ADDR_W(11)) dut (
      .CLK_24M      (clk),
      .nRESET       (nRESET),
      .CDA          (CDA),
      .nCRDC        (nCRDC),
      .nCRDO        (nCRDO),
      .nCRDW        (nCRDW),
      .M68K_DATA_LO (M68K_DATA_LO),
      .CARD_DATA    (CARD_DATA),
      .nCARD_WAIT   (nCARD_WAIT),
      .CARD_INSERTED(CARD_INSERTED),
      .CARD_WP      (CARD_WP),
      .MEM_ADDR     (MEM_ADDR),
      .MEM_WDATA    (MEM_WDATA),
      .MEM_WE       (MEM_WE),
      .MEM_REQ      (MEM_REQ),
      .MEM_ACK      (MEM_ACK),
      .MEM_RDATA    (MEM_RDATA),
      .DIRTY        (DIRTY),
      .DIRTY_CLR    (DIRTY_CLR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One strobe assertion held ncyc cycles; ack (and optional clear)
   // driven in cycle ack_at. Counts stall cycles and request pulses.
   task automatic run(input logic wr, input logic rd,
                      input logic [23:0] a, input logic [7:0] d,
                      input int ack_at, input logic clr_at_ack,
                      input int ncyc);
      logic prev;
      prev = MEM_REQ;
      wl = 0;
      rq = 0;
      CDA = a;
      M68K_DATA_LO = d;
      nCRDC = 1'b0;
      nCRDO = ~rd;
      nCRDW = ~wr;
      for (int c = 0; c < ncyc; c++) begin
         MEM_ACK   = (c == ack_at);
         DIRTY_CLR = clr_at_ack && (c == ack_at);
         #1;
         if (!nCARD_WAIT) wl++;
         if (MEM_REQ && !prev) rq++;
         prev = MEM_REQ;
         if (c == 1) begin
            sa  = MEM_ADDR;
            swe = MEM_WE;
            swd = MEM_WDATA;
         end
         tick();
      end
      MEM_ACK = 1'b0;
      DIRTY_CLR = 1'b0;
      nCRDC = 1'b1;
      nCRDO = 1'b1;
      nCRDW = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      nRESET = 1'b0;
      CDA = '0;
      nCRDC = 1'b1;
      nCRDO = 1'b1;
      nCRDW = 1'b1;
      M68K_DATA_LO = '0;
      CARD_INSERTED = 1'b1;
      CARD_WP = 1'b0;
      MEM_ACK = 1'b0;
      MEM_RDATA = '0;
      DIRTY_CLR = 1'b0;
      tick();
      tick();
      nRESET = 1'b1;
      tick();

      chk("rst_req",   {31'b0, MEM_REQ},    32'd0);
      chk("rst_we",    {31'b0, MEM_WE},     32'd0);
      chk("rst_addr",  {21'b0, MEM_ADDR},   32'd0);
      chk("rst_wdata", {24'b0, MEM_WDATA},  32'd0);
      chk("rst_cdata", {24'b0, CARD_DATA},  32'hFF);
      chk("rst_dirty", {31'b0, DIRTY},      32'd0);
      chk("rst_wait",  {31'b0, nCARD_WAIT}, 32'd1);

      // Read, ack 3 cycles after request rises.
      MEM_RDATA = 8'h5A;
      run(1'b0, 1'b1, 24'h000123, 8'h00, 4, 1'b0, 8);
      chk("rd_addr",  {21'b0, sa},        32'h123);
      chk("rd_we",    {31'b0, swe},       32'd0);
      chk("rd_wait",  wl,                 32'd5);
      chk("rd_reqs",  rq,                 32'd1);
      chk("rd_data",  {24'b0, CARD_DATA}, 32'h5A);
      chk("rd_dirty", {31'b0, DIRTY},     32'd0);

      // Write to a mirrored address, zero-wait ack.
      run(1'b1, 1'b0, 24'h200801, 8'hC3, 1, 1'b0, 4);
      chk("wr_addr",  {21'b0, sa},        32'h001);
      chk("wr_wdata", {24'b0, swd},       32'hC3);
      chk("wr_we",    {31'b0, swe},       32'd1);
      chk("wr_wait",  wl,                 32'd2);
      chk("wr_reqs",  rq,                 32'd1);
      chk("wr_dirty", {31'b0, DIRTY},     32'd1);
      chk("wr_cdata", {24'b0, CARD_DATA}, 32'h5A);

      // Protected write: no request, dirty untouched.
      CARD_WP = 1'b1;
      run(1'b1, 1'b0, 24'h000050, 8'h99, -1, 1'b0, 4);
      chk("wp_reqs",  rq,             32'd0);
      chk("wp_wait",  wl,             32'd1);
      chk("wp_dirty", {31'b0, DIRTY}, 32'd1);
      CARD_WP = 1'b0;

      // Absent card read returns FF without a request.
      CARD_INSERTED = 1'b0;
      run(1'b0, 1'b1, 24'h000060, 8'h00, -1, 1'b0, 4);
      chk("ab_reqs",  rq,                 32'd0);
      chk("ab_wait",  wl,                 32'd1);
      chk("ab_data",  {24'b0, CARD_DATA}, 32'hFF);
      chk("ab_dirty", {31'b0, DIRTY},     32'd1);
      CARD_INSERTED = 1'b1;

      // Clear alone, then clear colliding with a write ack.
      DIRTY_CLR = 1'b1;
      tick();
      DIRTY_CLR = 1'b0;
      tick();
      chk("clr_dirty", {31'b0, DIRTY}, 32'd0);
      run(1'b1, 1'b0, 24'h000002, 8'h11, 2, 1'b1, 4);
      chk("clrwr_dirty", {31'b0, DIRTY}, 32'd1);
      DIRTY_CLR = 1'b1;
      tick();
      DIRTY_CLR = 1'b0;
      tick();
      chk("clr2_dirty", {31'b0, DIRTY}, 32'd0);

      // Both strobes low: write wins; long strobe yields one request.
      run(1'b1, 1'b1, 24'h0007FE, 8'hA7, 2, 1'b0, 20);
      chk("both_we",    {31'b0, swe},   32'd1);
      chk("both_addr",  {21'b0, sa},    32'h7FE);
      chk("both_wdata", {24'b0, swd},   32'hA7);
      chk("both_reqs",  rq,             32'd1);
      chk("both_wait",  wl,             32'd3);
      chk("both_dirty", {31'b0, DIRTY}, 32'd1);

      // Top address wraps to the last card byte.
      MEM_RDATA = 8'h3C;
      run(1'b0, 1'b1, 24'hFFFFFF, 8'h00, 1, 1'b0, 4);
      chk("top_addr", {21'b0, sa},        32'h7FF);
      chk("top_data", {24'b0, CARD_DATA}, 32'h3C);

      // Reset asserted while a request is outstanding.
      CDA = 24'h000456;
      nCRDC = 1'b0;
      nCRDO = 1'b0;
      #1;
      chk("mr_wait0", {31'b0, nCARD_WAIT}, 32'd0);
      tick();
      #1;
      chk("mr_req1", {31'b0, MEM_REQ}, 32'd1);
      nRESET = 1'b0;
      #1;
      chk("mr_req0",  {31'b0, MEM_REQ},   32'd0);
      chk("mr_cdata", {24'b0, CARD_DATA}, 32'hFF);
      chk("mr_dirty", {31'b0, DIRTY},     32'd0);
      chk("mr_addr",  {21'b0, MEM_ADDR},  32'd0);
      nCRDC = 1'b1;
      nCRDO = 1'b1;
      tick();
      nRESET = 1'b1;
      tick();
      chk("mr_idle", {31'b0, nCARD_WAIT}, 32'd1);

      MEM_RDATA = 8'h77;
      run(1'b0, 1'b1, 24'h000010, 8'h00, 1, 1'b0, 4);
      chk("post_reqs", rq,                 32'd1);
      chk("post_wait", wl,                 32'd2);
      chk("post_addr", {21'b0, sa},        32'h010);
      chk("post_data", {24'b0, CARD_DATA}, 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neo_memcard.md
# neo_memcard

Memory card controller directly downstream of the vector-swap/card-address stage. Consumes the 24-bit card address (bank in bits 23:21, word index in bits 20:0) and the card strobes. Runs byte-wide read/write transactions against a request/acknowledge backing-store port (BRAM or SDRAM arbiter), stalls the 68k while a transaction is outstanding, and tracks a dirty flag so the host can save the card image.

## Interface
- ADDR_W, 11: backing-store address width (2 KiB card). Legal range 1–24.
- CLK_24M  in  1  system clock; all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- CDA  in  24  card byte address; only CDA[ADDR_W-1:0] is used, so higher addresses mirror.
- nCRDC  in  1  card chip enable, active low.
- nCRDO  in  1  card output enable (read), active low.
- nCRDW  in  1  card write enable, active low.
- M68K_DATA_LO  in  8  68k data bus D7:D0 for writes.
- CARD_DATA  out  8  read data to the 68k bus mux.
- nCARD_WAIT  out  1  low stalls the 68k DTACK path.
- CARD_INSERTED  in  1  1 = card present.
- CARD_WP  in  1  1 = write protected.
- MEM_ADDR  out  ADDR_W  backing-store address.
- MEM_WDATA  out  8  write data.
- MEM_WE  out  1  1 = write request, 0 = read request.
- MEM_REQ  out  1  request, level, held until acknowledged.
- MEM_ACK  in  1  single-cycle acknowledge; read data is valid in the same cycle.
- MEM_RDATA  in  8  read data.
- DIRTY  out  1  card contents modified since the last clear.
- DIRTY_CLR  in  1  single-cycle pulse from the host after a save.

## Operation
- Access condition `sel`: nCRDC=0 and (nCRDO=0 or nCRDW=0). Write has priority when nCRDO and nCRDW are both low.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - When `sel` is true, register CDA[ADDR_W-1:0] into MEM_ADDR, M68K_DATA_LO into MEM_WDATA, and the write flag into MEM_WE.
  - Card present and not (write and CARD_WP): go to REQ with MEM_REQ=1.
  - Card absent read: CARD_DATA=8'hFF, go to HOLD.
  - Card absent write, or protected write: go to HOLD with no request and no dirty change.
- REQ:
  - MEM_REQ and all MEM_* outputs stay stable until MEM_ACK.
  - On MEM_ACK: MEM_REQ=0; for a read, CARD_DATA<=MEM_RDATA; for a write, DIRTY<=1. Go to HOLD.
- HOLD: wait until `sel` is false, then return to IDLE. One strobe assertion produces exactly one transaction.
- nCARD_WAIT = ~((state==IDLE & sel) | state==REQ). The stall is combinational so the 68k is held from the first cycle.
- CARD_DATA keeps its last value outside read completion.
- DIRTY_CLR clears DIRTY. If DIRTY_CLR and a write-ack arrive in the same cycle, the set wins and DIRTY stays 1.
- CARD_INSERTED or CARD_WP changing during REQ does not abort the transaction; the values sampled in IDLE apply.
- Strobe release during REQ: the transaction still completes, then HOLD exits on the next cycle.
- Reset values: state=IDLE, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CARD_DATA=8'hFF, DIRTY=0. nCARD_WAIT follows its equation.
- Reset asserted mid-REQ drops MEM_REQ immediately. The backend must tolerate an abandoned request.

## Timing
- Cycle 0: `sel` seen in IDLE; nCARD_WAIT=0 combinationally. Address and data registered at the cycle-0 edge.
- Cycle 1: MEM_REQ=1, state REQ.
- Cycle k: MEM_ACK=1.
- Cycle k+1: MEM_REQ=0, CARD_DATA valid (read), DIRTY=1 (write), nCARD_WAIT=1.
- Minimum strobe-to-release latency with a zero-wait backend (ack in cycle 1): 2 cycles.
- No-request paths (absent card, protected write): nCARD_WAIT=1 from cycle 1; CARD_DATA=FF valid at cycle 1.
- A new access needs one cycle or more of `sel` false between strobes.

## Structure
- Shared package neo_memcard_pkg holds:
  - the state enum (IDLE, REQ, HOLD);
  - the constant CARD_EMPTY_DATA = 8'hFF.
- Single module; no sub-module is needed. The FSM and datapath are both small.

## Test plan
- Read, card present, ack 3 cycles after MEM_REQ rises: CDA=24'h000123, RDATA=8'h5A -> MEM_ADDR=11'h123, MEM_WE=0, nCARD_WAIT low for 5 cycles, CARD_DATA=8'h5A, one request only.
- Write to mirrored address: CDA=24'h200801, D=8'hC3, ADDR_W=11 -> MEM_ADDR=11'h001, MEM_WDATA=C3, MEM_WE=1, DIRTY=1 after ack.
- CARD_WP=1 write, then CARD_INSERTED=0 read -> no MEM_REQ in either case, DIRTY unchanged, read CARD_DATA=FF, nCARD_WAIT high at cycle 1.
- DIRTY_CLR in the same cycle as a write MEM_ACK -> DIRTY=1. DIRTY_CLR alone on a later cycle -> DIRTY=0.
- nCRDO and nCRDW both low -> write performed. Strobe held for 20 cycles -> exactly one MEM_REQ pulse.
- nRESET pulsed low during REQ -> MEM_REQ=0 at once, CARD_DATA=FF, state IDLE. Next strobe runs normally.
